// File: rtl/tick_monitor_if.sv
// Bundle of the square-wave input, error clear and measurement outputs for tick_monitor.
// tick is a valid-only strobe (no ready): period is valid in every cycle that tick is high.
interface tick_monitor_if #(
  parameter int CW = 12
);
  logic          sq_in;
  logic          err_clr;
  logic          tick;
  logic [CW-1:0] period;
  logic          locked;
  logic          err;
  logic [1:0]    state;

  modport master (
    output sq_in, err_clr,
    input  tick, period, locked, err, state
  );

  modport slave (
    input  sq_in, err_clr,
    output tick, period, locked, err, state
  );
endinterface

// File: rtl/tick_monitor.sv
// Square-wave period monitor: synchronizes sq_in, measures periods, locks after LOCK_N good periods.
// Define TICK_MON_DUTY_CHECK_EN to also require the high time to be within TOL of HALF_CNT.
module tick_monitor #(
  parameter int HALF_CNT = 800,
  parameter int TOL      = 4,
  parameter int LOCK_N   = 4,
  parameter int CW       = 12
) (
  input  logic           clk,
  input  logic           rst,
  tick_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

  localparam int            GN_W     = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] PER_TGT  = CW'(2 * HALF_CNT);
  localparam logic [CW-1:0] TMO_CNT  = CW'(2 * HALF_CNT + TOL + 1);
  localparam logic [CW-1:0] TOL_C    = CW'(TOL);
  localparam logic [GN_W-1:0] LOCK_N_C = GN_W'(LOCK_N);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [GN_W-1:0] good_n_q, good_n_d;
  logic [GN_W-1:0] good_n_inc;
  state_t state_q, state_d;
  logic tick_q, tick_d;
  logic err_q, err_d;

  logic rise;
  logic timeout;
  logic per_ok;
  logic rise_good;
  logic [CW-1:0] per_dev;

`ifdef TICK_MON_DUTY_CHECK_EN
  localparam logic [CW-1:0] HALF_TGT = CW'(HALF_CNT);
  logic fall;
  logic duty_ok;
  logic [CW-1:0] hi_dev;
  logic [CW-1:0] hi_len_q, hi_len_d;
`endif

  // Edge detection and measurement datapath
  always_comb begin
    s1_d = bus.sq_in;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;

    if (rise)
      cnt_d = {{(CW-1){1'b0}}, 1'b1};
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    else
      cnt_d = cnt_q;

    period_d = rise ? cnt_q : period_q;
    timeout  = !rise && (cnt_q == TMO_CNT);

    per_dev = (cnt_q >= PER_TGT) ? (cnt_q - PER_TGT) : (PER_TGT - cnt_q);
    per_ok  = (per_dev <= TOL_C);
  end

`ifdef TICK_MON_DUTY_CHECK_EN
  always_comb begin
    fall      = ~s2_q & s3_q;
    hi_len_d  = fall ? cnt_q : hi_len_q;
    hi_dev    = (hi_len_q >= HALF_TGT) ? (hi_len_q - HALF_TGT) : (HALF_TGT - hi_len_q);
    duty_ok   = (hi_dev <= TOL_C);
    rise_good = per_ok && duty_ok;
  end
`else
  always_comb begin
    rise_good = per_ok;
  end
`endif

  // FSM: state register together with the datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      good_n_q <= '0;
      state_q  <= ST_IDLE;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef TICK_MON_DUTY_CHECK_EN
      hi_len_q <= '0;
`endif
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      good_n_q <= good_n_d;
      state_q  <= state_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
`ifdef TICK_MON_DUTY_CHECK_EN
      hi_len_q <= hi_len_d;
`endif
    end
  end

  // FSM: next state
  always_comb begin
    state_d    = state_q;
    good_n_d   = good_n_q;
    good_n_inc = good_n_q + GN_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d  = ST_ACQ;
          good_n_d = '0;
        end
      end
      ST_ACQ: begin
        if (rise) begin
          if (rise_good) begin
            good_n_d = good_n_inc;
            if (good_n_inc >= LOCK_N_C)
              state_d = ST_LOCKED;
          end else begin
            good_n_d = '0;
          end
        end else if (timeout) begin
          state_d  = ST_IDLE;
          good_n_d = '0;
        end
      end
      ST_LOCKED: begin
        if ((rise && !rise_good) || timeout)
          state_d = ST_LOST;
      end
      ST_LOST: begin
        if (rise && rise_good) begin
          state_d  = ST_ACQ;
          good_n_d = GN_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        good_n_d = '0;
      end
    endcase
  end

  // FSM: outputs; a new loss of lock beats a coincident err_clr
  always_comb begin
    tick_d = rise && (state_d == ST_LOCKED);
    if ((state_q == ST_LOCKED) && (state_d == ST_LOST))
      err_d = 1'b1;
    else if (bus.err_clr)
      err_d = 1'b0;
    else
      err_d = err_q;
  end

  assign bus.tick   = tick_q;
  assign bus.period = period_q;
  assign bus.locked = (state_q == ST_LOCKED);
  assign bus.err    = err_q;
  assign bus.state  = state_q;

endmodule
